// File: rtl/ctrl_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipeline
//  Description : EX/MEM/WB control-bundle pipeline with load-use stall,
//                branch/jump flush, operand forwarding select and a
//                retired-instruction counter.
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_pipeline #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic                  id_attempt_branch,
   input  logic                  id_is_jalr,
   input  logic                  id_jump,
   input  logic                  id_reg_write,
   input  logic                  id_mem_to_reg,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  id_immediate,
   input  logic                  id_auipc,
   input  logic [2:0]            id_alu_op,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  ex_branch_taken,
   input  logic                  mem_stall,
   output logic                  ex_valid,
   output logic                  ex_attempt_branch,
   output logic                  ex_is_jalr,
   output logic                  ex_jump,
   output logic                  ex_reg_write,
   output logic                  ex_mem_to_reg,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_immediate,
   output logic                  ex_auipc,
   output logic [2:0]            ex_alu_op,
   output logic [REG_ADDR_W-1:0] ex_rs1,
   output logic [REG_ADDR_W-1:0] ex_rs2,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  mem_valid,
   output logic                  mem_reg_write,
   output logic                  mem_mem_to_reg,
   output logic                  mem_mem_read,
   output logic                  mem_mem_write,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  wb_valid,
   output logic                  wb_reg_write,
   output logic                  wb_mem_to_reg,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  stall_if_id,
   output logic                  flush_if_id,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic [CNT_W-1:0]      instret
);

   localparam logic [1:0] C_FWD_RF  = 2'b00;
   localparam logic [1:0] C_FWD_MEM = 2'b10;
   localparam logic [1:0] C_FWD_WB  = 2'b01;

   logic w_redirect;
   logic w_load_use;
   logic w_ex_load;

   assign w_redirect = ex_valid & (ex_jump | (ex_attempt_branch & ex_branch_taken));
   assign w_load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                       ((ex_rd == id_rs1) | (ex_rd == id_rs2));

   // A redirect wins over load-use: the ID instruction is killed, so no stall.
   assign stall_if_id = mem_stall | (~w_redirect & w_load_use);
   assign flush_if_id = ~mem_stall & w_redirect;

   // EX captures the ID bundle only for a live, unhazarded instruction.
   assign w_ex_load = id_valid & ~w_redirect & ~w_load_use;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid          <= 1'b0;
         ex_attempt_branch <= 1'b0;
         ex_is_jalr        <= 1'b0;
         ex_jump           <= 1'b0;
         ex_reg_write      <= 1'b0;
         ex_mem_to_reg     <= 1'b0;
         ex_mem_read       <= 1'b0;
         ex_mem_write      <= 1'b0;
         ex_immediate      <= 1'b0;
         ex_auipc          <= 1'b0;
         ex_alu_op         <= '0;
         ex_rs1            <= '0;
         ex_rs2            <= '0;
         ex_rd             <= '0;
      end else if (!mem_stall) begin
         ex_valid          <= w_ex_load;
         ex_attempt_branch <= w_ex_load & id_attempt_branch;
         ex_is_jalr        <= w_ex_load & id_is_jalr;
         ex_jump           <= w_ex_load & id_jump;
         ex_reg_write      <= w_ex_load & id_reg_write;
         ex_mem_to_reg     <= w_ex_load & id_mem_to_reg;
         ex_mem_read       <= w_ex_load & id_mem_read;
         ex_mem_write      <= w_ex_load & id_mem_write;
         ex_immediate      <= w_ex_load & id_immediate;
         ex_auipc          <= w_ex_load & id_auipc;
         ex_alu_op         <= w_ex_load ? id_alu_op : '0;
         ex_rs1            <= w_ex_load ? id_rs1    : '0;
         ex_rs2            <= w_ex_load ? id_rs2    : '0;
         ex_rd             <= w_ex_load ? id_rd     : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_valid      <= 1'b0;
         mem_reg_write  <= 1'b0;
         mem_mem_to_reg <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
         mem_rd         <= '0;
         wb_valid       <= 1'b0;
         wb_reg_write   <= 1'b0;
         wb_mem_to_reg  <= 1'b0;
         wb_rd          <= '0;
         instret        <= '0;
      end else if (!mem_stall) begin
         mem_valid      <= ex_valid;
         mem_reg_write  <= ex_reg_write;
         mem_mem_to_reg <= ex_mem_to_reg;
         mem_mem_read   <= ex_mem_read;
         mem_mem_write  <= ex_mem_write;
         mem_rd         <= ex_rd;
         wb_valid       <= mem_valid;
         wb_reg_write   <= mem_reg_write;
         wb_mem_to_reg  <= mem_mem_to_reg;
         wb_rd          <= mem_rd;
         if (wb_valid) begin
            instret <= instret + CNT_W'(1);
         end
      end
   end

   // x0 is never forwarded; the younger MEM result beats WB.
   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
      logic [1:0] sel;
      sel = C_FWD_RF;
      if (rs != '0) begin
         if (mem_valid && mem_reg_write && (mem_rd == rs)) begin
            sel = C_FWD_MEM;
         end else if (wb_valid && wb_reg_write && (wb_rd == rs)) begin
            sel = C_FWD_WB;
         end
      end
      return sel;
   endfunction

   assign fwd_a = fwd_sel(ex_rs1);
   assign fwd_b = fwd_sel(ex_rs2);

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_pipeline
//  Description : Directed plus random bench for ctrl_pipeline against a
//                queue-based pipeline reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_pipeline;

   localparam int CW  = 4;
   localparam int MOD = 1 << CW;

   typedef struct packed {
      logic       v, br, jalr, jump, rw, m2r, mr, mw, imm, auipc;
      logic [2:0] op;
      logic [4:0] rs1, rs2, rd;
   } bundle_t;

   logic clk = 1'b0;
   logic rst_n;
   logic id_valid, id_attempt_branch, id_is_jalr, id_jump, id_reg_write;
   logic id_mem_to_reg, id_mem_read, id_mem_write, id_immediate, id_auipc;
   logic [2:0] id_alu_op;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic ex_branch_taken, mem_stall;
   logic ex_valid, ex_attempt_branch, ex_is_jalr, ex_jump, ex_reg_write;
   logic ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_immediate, ex_auipc;
   logic [2:0] ex_alu_op;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic mem_valid, mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write;
   logic [4:0] mem_rd;
   logic wb_valid, wb_reg_write, wb_mem_to_reg;
   logic [4:0] wb_rd;
   logic stall_if_id, flush_if_id;
   logic [1:0] fwd_a, fwd_b;
   logic [CW-1:0] instret;

   always #5 clk = ~clk;

   ctrl_pipeline #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_attempt_branch(id_attempt_branch), .id_is_jalr(id_is_jalr),
      .id_jump(id_jump), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_immediate(id_immediate),
      .id_auipc(id_auipc), .id_alu_op(id_alu_op), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
      .ex_valid(ex_valid), .ex_attempt_branch(ex_attempt_branch), .ex_is_jalr(ex_is_jalr),
      .ex_jump(ex_jump), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_immediate(ex_immediate),
      .ex_auipc(ex_auipc), .ex_alu_op(ex_alu_op), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_rd(mem_rd),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
      .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .instret(instret)
   );

   bundle_t dut_ex;
   assign dut_ex = {ex_valid, ex_attempt_branch, ex_is_jalr, ex_jump, ex_reg_write,
                    ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_immediate, ex_auipc,
                    ex_alu_op, ex_rs1, ex_rs2, ex_rd};

   int          total = 0;
   int          bad   = 0;
   bundle_t     pipe[$];      // [0]=EX, [1]=MEM, [2]=WB
   int unsigned cnt;
   bundle_t     id_cur;
   bit          held;
   logic [1:0]  obs_fwd_a, obs_fwd_b;
   logic        obs_stall, obs_flush, obs_exv;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bundle_t mk(bit v, bit rw, bit mr, bit br, bit jmp,
                                  int rd, int rs1, int rs2);
      bundle_t b;
      b = '0;
      b.v = v; b.rw = rw; b.mr = mr; b.m2r = mr; b.br = br; b.jump = jmp;
      b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2);
      return b;
   endfunction

   function automatic bundle_t rnd();
      bundle_t b;
      b = bundle_t'($urandom);
      b.v    = ($urandom_range(0, 3) != 0);
      b.jump = ($urandom_range(0, 7) == 0);
      b.br   = ($urandom_range(0, 3) == 0);
      b.mr   = ($urandom_range(0, 2) == 0);
      b.rd   = 5'($urandom_range(0, 3));
      b.rs1  = 5'($urandom_range(0, 3));
      b.rs2  = 5'($urandom_range(0, 3));
      return b;
   endfunction

   function automatic logic [1:0] exp_fwd(logic [4:0] rs);
      if (rs == 0) return 2'b00;
      if (pipe[1].v && pipe[1].rw && pipe[1].rd == rs) return 2'b10;
      if (pipe[2].v && pipe[2].rw && pipe[2].rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic void model_reset();
      pipe = '{'0, '0, '0};
      cnt  = 0;
   endfunction

   // Called just after a rising edge; drives id_cur, checks at the falling edge.
   task automatic run_cycle(input bit ms, input bit bt);
      bundle_t ex;
      bit red, lu, exp_st, exp_fl;
      {id_valid, id_attempt_branch, id_is_jalr, id_jump, id_reg_write, id_mem_to_reg,
       id_mem_read, id_mem_write, id_immediate, id_auipc, id_alu_op, id_rs1, id_rs2, id_rd} = id_cur;
      mem_stall = ms;
      ex_branch_taken = bt;
      @(negedge clk);
      ex  = pipe[0];
      red = ex.v && (ex.jump || (ex.br && bt));
      lu  = id_cur.v && ex.v && ex.mr && ex.rd != 0 && (ex.rd == id_cur.rs1 || ex.rd == id_cur.rs2);
      exp_st = 0; exp_fl = 0;
      if (ms) exp_st = 1;
      else if (red) exp_fl = 1;
      else if (lu) exp_st = 1;
      chk("ex_bundle", 32'(dut_ex), 32'(pipe[0]));
      chk("mem_stage", 32'({mem_valid, mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write, mem_rd}),
          32'({pipe[1].v, pipe[1].rw, pipe[1].m2r, pipe[1].mr, pipe[1].mw, pipe[1].rd}));
      chk("wb_stage", 32'({wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd}),
          32'({pipe[2].v, pipe[2].rw, pipe[2].m2r, pipe[2].rd}));
      chk("instret", 32'(instret), cnt);
      chk("stall_if_id", 32'(stall_if_id), 32'(exp_st));
      chk("flush_if_id", 32'(flush_if_id), 32'(exp_fl));
      chk("fwd_a", 32'(fwd_a), 32'(exp_fwd(ex.rs1)));
      chk("fwd_b", 32'(fwd_b), 32'(exp_fwd(ex.rs2)));
      obs_fwd_a = fwd_a; obs_fwd_b = fwd_b;
      obs_stall = stall_if_id; obs_flush = flush_if_id; obs_exv = ex_valid;
      if (!ms) begin
         if (pipe[2].v) cnt = (cnt + 1) % MOD;
         pipe.push_front((red || lu || !id_cur.v) ? bundle_t'('0) : id_cur);
         void'(pipe.pop_back());
      end
      held = exp_st;
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction until ID accepts it; n = cycles it spent in ID.
   task automatic feed(input bundle_t b, input bit bt, output int n);
      id_cur = b;
      n = 0;
      do begin
         run_cycle(1'b0, bt);
         n++;
      end while (held && n < 8);
      if (held) begin
         total++; bad++;
         $error("FAIL feed_timeout observed=held expected=accepted");
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ex"}, 32'(dut_ex), 32'(0));
      chk({tag, "_mem"}, 32'({mem_valid, mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write, mem_rd}), 0);
      chk({tag, "_wb"}, 32'({wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd}), 0);
      chk({tag, "_instret"}, 32'(instret), 0);
      chk({tag, "_ctl"}, 32'({stall_if_id, flush_if_id, fwd_a, fwd_b}), 0);
   endtask

   initial begin
      bundle_t nop, b;
      int n;
      nop = mk(1, 1, 0, 0, 0, 9, 0, 0);
      rst_n = 1'b0; mem_stall = 1'b0; ex_branch_taken = 1'b0;
      id_cur = mk(1, 1, 1, 0, 0, 1, 1, 1);
      {id_valid, id_attempt_branch, id_is_jalr, id_jump, id_reg_write, id_mem_to_reg,
       id_mem_read, id_mem_write, id_immediate, id_auipc, id_alu_op, id_rs1, id_rs2, id_rd} = id_cur;
      model_reset();
      held = 0;
      @(posedge clk); #1;
      chk_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // ADD x1 ; ADD x2,x1,x3 -> MEM forward on A only
      feed(mk(1, 1, 0, 0, 0, 1, 4, 4), 0, n);
      feed(mk(1, 1, 0, 0, 0, 2, 1, 3), 0, n);
      chk("fwd_add_nostall", 32'(n), 1);
      feed(nop, 0, n);
      chk("fwd_add_a", 32'(obs_fwd_a), 32'(2'b10));
      chk("fwd_add_b", 32'(obs_fwd_b), 32'(2'b00));

      // LW x5 ; ADD x6,x5,x5 -> one bubble, then WB forward on both
      feed(mk(1, 1, 1, 0, 0, 5, 2, 0), 0, n);
      feed(mk(1, 1, 0, 0, 0, 6, 5, 5), 0, n);
      chk("lu_cycles", 32'(n), 2);
      feed(nop, 0, n);
      chk("lu_fwd", 32'({obs_fwd_a, obs_fwd_b}), 32'(4'b0101));

      // LW x0 ; use of x0 -> no hazard
      feed(mk(1, 1, 1, 0, 0, 0, 2, 0), 0, n);
      feed(mk(1, 1, 0, 0, 0, 7, 0, 0), 0, n);
      chk("x0_nostall", 32'(n), 1);
      feed(nop, 0, n);
      chk("x0_fwd_a", 32'(obs_fwd_a), 0);

      // Branch taken / not taken, jump regardless of compare result
      feed(mk(1, 0, 0, 1, 0, 0, 1, 2), 0, n);
      feed(nop, 1, n);
      chk("beq_taken_flush", 32'(obs_flush), 1);
      feed(nop, 0, n);
      chk("beq_taken_bubble", 32'(obs_exv), 0);
      feed(mk(1, 0, 0, 1, 0, 0, 1, 2), 0, n);
      feed(nop, 0, n);
      chk("beq_nt_flush", 32'(obs_flush), 0);
      feed(mk(1, 1, 0, 0, 1, 1, 0, 0), 0, n);
      feed(nop, 0, n);
      chk("jal_flush", 32'(obs_flush), 1);

      // Redirect and load-use together -> flush wins, single bubble
      feed(mk(1, 1, 1, 0, 1, 5, 0, 0), 0, n);
      feed(mk(1, 1, 0, 0, 0, 6, 5, 5), 0, n);
      chk("combo_cycles", 32'(n), 1);
      chk("combo_ctl", 32'({obs_flush, obs_stall}), 32'(2'b10));
      feed(nop, 0, n);
      chk("combo_bubble", 32'(obs_exv), 0);

      // Three-cycle memory stall mid-stream
      feed(mk(1, 1, 0, 0, 0, 3, 1, 2), 0, n);
      feed(mk(1, 1, 1, 0, 0, 4, 3, 0), 0, n);
      id_cur = mk(1, 1, 0, 0, 0, 8, 4, 3);
      for (int i = 0; i < 3; i++) begin
         run_cycle(1'b1, 1'b0);
         chk("mstall_stall", 32'(obs_stall), 1);
      end
      feed(id_cur, 0, n);
      feed(nop, 0, n);
      feed(nop, 0, n);

      // Asynchronous reset mid-stream
      feed(mk(1, 1, 0, 0, 0, 2, 1, 1), 0, n);
      #2 rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      model_reset();
      @(posedge clk); #1;
      chk_zero("held_rst");
      rst_n = 1'b1;
      held = 0;

      // Random traffic; the narrow counter wraps several times
      for (int i = 0; i < 400; i++) begin
         if (!held) id_cur = rnd();
         b = id_cur;
         id_cur = b;
         run_cycle(($urandom_range(0, 5) == 0), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
